axi_stream_slave_verifier: RTL and testbench
============================================

# axi_stream_slave_verifier

Ingress-direction protocol guard placed between the network-side AXI-Stream master and an untrusted user slave. Registers every beat toward the slave, detects a slave that holds tready low for too long, and isolates it: the stalled beat and the rest of its packet are discarded, and whole packets are dropped until software acknowledges. Upstream is never back-pressured indefinitely by a misbehaving slave.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64, tdata width in bits (multiple of 8)
- AXIS_ID_WIDTH, 4, tid width
- AXIS_DEST_WIDTH, 4, tdest width
- TIMEOUT_CYCLES, 1024, consecutive stalled cycles that constitute a timeout (≥2)

Ports:
- aclk  in  1  clock; all interfaces synchronous to it
- aresetn  in  1  reset, asynchronous assert, active-low
- axis_s_tdata/tid/tdest/tkeep/tlast/tvalid  in  widths per params  upstream (network) stream
- axis_s_tready  out  1  upstream ready
- axis_m_tdata/tid/tdest/tkeep/tlast/tvalid  out  widths per params  stream to user slave
- axis_m_tready  in  1  slave ready
- timeout_error_irq  out  1  sticky timeout indication
- timeout_error_clear  in  1  single-cycle acknowledge
- beats_dropped  out  16  saturating count of discarded upstream beats

## Operation
- Output register (reg_tvalid + payload); axis_m_* driven only from registers.
- States: IDLE (no upstream packet open), PASS (upstream packet open), DRAIN (discard until upstream tlast), DECOUPLED (discard whole packets).
- IDLE/PASS: axis_s_tready = axis_m_tready || !reg_tvalid; handshake loads register. IDLE→PASS on accepted beat without tlast; PASS→IDLE on accepted tlast.
- DRAIN/DECOUPLED: axis_s_tready = 1; accepted beats discarded, beats_dropped += 1 (saturates at 0xFFFF).
- Stall timer: increments each cycle reg_tvalid && !axis_m_tready; cleared on downstream handshake or when reg_tvalid = 0.
- Timeout event: timer = TIMEOUT_CYCLES-1 and still stalled. Effects at that edge: reg_tvalid←0 (held beat dropped, counted), timeout_error←1, state→DRAIN if upstream packet open (in_pkt) and held beat not tlast, else DECOUPLED.
- DRAIN→DECOUPLED on accepted upstream tlast.
- DECOUPLED→IDLE when timeout_error = 0 and in_pkt = 0.
- timeout_error_clear clears the sticky flag in any state; simultaneous timeout event wins (flag stays 1).
- timeout_error_irq = timeout_error.
- Upstream beat accepted in the same cycle as a timeout event is treated by the pre-timeout state (loaded only if register was being freed; otherwise not accepted).

## Timing
- Reset (async): reg_tvalid=0, axis_m_* payload=0, axis_s_tready=0 while aresetn low, timeout_error=0, beats_dropped=0, state IDLE, timer 0.
- Latency upstream→downstream: 1 cycle; full throughput (1 beat/cycle) when slave ready.
- Timeout fires at the edge ending the TIMEOUT_CYCLES-th consecutive stalled cycle; axis_m_tvalid low from next cycle.
- Once axis_m_tvalid is asserted, payload is stable until handshake or timeout.
- Reset mid-packet: all state discarded; upstream partial packet resumes as if IDLE (not drained).

## Configuration
- AXIS_SLAVE_VERIF_TLAST_INJECT_EN defined: track downstream open packet (out_pkt, set on handshake without tlast, cleared on tlast). On timeout with out_pkt = 1, set inject_pending; present a terminator beat tvalid=1, tlast=1, tkeep=0, tdata=0, tid/tdest of last beat, held until handshake (stall timer disabled for it). DECOUPLED→IDLE additionally requires inject_pending = 0.
- Not defined: no terminator; slave may see an unterminated packet.

## Structure
- Package axis_verif_pkg: state enum typedef (IDLE, PASS, DRAIN, DECOUPLED), beats_dropped width constant.
- Sub-module axis_stall_timer: counter of width $clog2(TIMEOUT_CYCLES+1), inputs stall/clear, output expire.

## Test plan
- 4-beat packet, tready high → axis_m matches input 1 cycle later, no irq, beats_dropped=0.
- TIMEOUT_CYCLES=8, slave stalls after beat 1 of 6-beat packet → irq at 8th stalled cycle, remaining beats drained, beats_dropped=5, state DECOUPLED.
- While DECOUPLED, send two 3-beat packets → none reach slave, beats_dropped +6; pulse clear between packets → next packet passes intact.
- Stall of TIMEOUT_CYCLES-1 cycles then tready → no timeout, timer resets, packet intact.
- Clear pulse in same cycle as timeout event → irq remains 1.
- With AXIS_SLAVE_VERIF_TLAST_INJECT_EN, timeout after 2 accepted beats → slave then receives one beat tlast=1, tkeep=0 before any new packet.

Source files
------------

// File: rtl/axis_verif_pkg.sv
// Shared types and constants for the AXI-Stream slave verifier.
package axis_verif_pkg;

  // Guard state: IDLE/PASS forward traffic, DRAIN/DECOUPLED discard it
  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN,
    DECOUPLED
  } vstate_e;

  localparam int                        BEATS_DROPPED_W   = 16;
  localparam logic [BEATS_DROPPED_W-1:0] BEATS_DROPPED_MAX = '1;

endpackage

// File: rtl/axis_stall_timer.sv
// Counts consecutive stalled cycles; expire_o pulses in the cycle that
// would complete TIMEOUT_CYCLES stalled cycles in a row.
module axis_stall_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic stall_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = stall_i && (cnt_q == LAST);

  // Restart on expiry or clear, otherwise advance while stalled
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) cnt_d = '0;
    else if (stall_i)        cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi_stream_slave_verifier.sv
// Ingress guard between the network AXI-Stream master and an untrusted user
// slave. A slave stalling TIMEOUT_CYCLES in a row is isolated: the held beat
// and the rest of its packet are discarded, then whole packets are dropped
// until software clears the sticky error.
// Optional: AXIS_SLAVE_VERIF_TLAST_INJECT_EN closes a packet the slave had
// already started with a zero-keep tlast terminator beat.
module axi_stream_slave_verifier
  import axis_verif_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_s_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]    axis_s_tid,
  input  logic [AXIS_DEST_WIDTH-1:0]  axis_s_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0] axis_s_tkeep,
  input  logic                        axis_s_tlast,
  input  logic                        axis_s_tvalid,
  output logic                        axis_s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_m_tdata,
  output logic [AXIS_ID_WIDTH-1:0]    axis_m_tid,
  output logic [AXIS_DEST_WIDTH-1:0]  axis_m_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0] axis_m_tkeep,
  output logic                        axis_m_tlast,
  output logic                        axis_m_tvalid,
  input  logic                        axis_m_tready,
  output logic                        timeout_error_irq,
  input  logic                        timeout_error_clear,
  output logic [15:0]                 beats_dropped
);

  localparam int KW = AXIS_BUS_WIDTH / 8;

  vstate_e                      state_q, state_d;
  logic                         reg_vld_q, reg_vld_d;
  logic [AXIS_BUS_WIDTH-1:0]    reg_data_q, reg_data_d;
  logic [AXIS_ID_WIDTH-1:0]     reg_id_q, reg_id_d;
  logic [AXIS_DEST_WIDTH-1:0]   reg_dest_q, reg_dest_d;
  logic [KW-1:0]                reg_keep_q, reg_keep_d;
  logic                         reg_last_q, reg_last_d;
  logic                         in_pkt_q, in_pkt_d;
  logic                         tmo_err_q, tmo_err_d;
  logic [BEATS_DROPPED_W-1:0]   dropped_q, dropped_d;
  logic                         pass_st, up_acc, m_hs, stall, expire, inj_active;

`ifdef AXIS_SLAVE_VERIF_TLAST_INJECT_EN
  logic out_pkt_q, out_pkt_d;
  logic inj_q, inj_d;
  assign inj_active = inj_q;
`else
  assign inj_active = 1'b0;
`endif

  assign pass_st       = (state_q == IDLE) || (state_q == PASS);
  // Discarding states never back-pressure; tready is held low in reset
  assign axis_s_tready = aresetn && (pass_st ? (axis_m_tready || !reg_vld_q) : 1'b1);
  assign up_acc        = axis_s_tvalid && axis_s_tready;
  assign m_hs          = reg_vld_q && axis_m_tready;
  // The terminator beat is never timed out
  assign stall         = reg_vld_q && !axis_m_tready && !inj_active;
  assign in_pkt_d      = up_acc ? !axis_s_tlast : in_pkt_q;

  axis_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .stall_i (stall),
    .clear_i (!reg_vld_q || m_hs || inj_active),
    .expire_o(expire)
  );

  // Output register: unload on handshake, load when forwarding, drop on timeout
  always_comb begin
    reg_vld_d  = reg_vld_q;
    reg_data_d = reg_data_q;
    reg_id_d   = reg_id_q;
    reg_dest_d = reg_dest_q;
    reg_keep_d = reg_keep_q;
    reg_last_d = reg_last_q;
`ifdef AXIS_SLAVE_VERIF_TLAST_INJECT_EN
    out_pkt_d  = out_pkt_q;
    inj_d      = inj_q;
    if (m_hs) begin
      out_pkt_d = !reg_last_q;
      inj_d     = 1'b0;
    end
`endif
    if (m_hs) reg_vld_d = 1'b0;
    if (pass_st && up_acc) begin
      reg_vld_d  = 1'b1;
      reg_data_d = axis_s_tdata;
      reg_id_d   = axis_s_tid;
      reg_dest_d = axis_s_tdest;
      reg_keep_d = axis_s_tkeep;
      reg_last_d = axis_s_tlast;
    end
    if (expire) begin
      reg_vld_d = 1'b0;
`ifdef AXIS_SLAVE_VERIF_TLAST_INJECT_EN
      // Slave saw an open packet: replace held beat with a terminator
      if (out_pkt_q) begin
        reg_vld_d  = 1'b1;
        reg_data_d = '0;
        reg_keep_d = '0;
        reg_last_d = 1'b1;
        inj_d      = 1'b1;
      end
`endif
    end
  end

  // Guard FSM next state, sticky error and drop counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (up_acc && !axis_s_tlast) state_d = PASS;
      PASS:      if (up_acc &&  axis_s_tlast) state_d = IDLE;
      DRAIN:     if (up_acc &&  axis_s_tlast) state_d = DECOUPLED;
      DECOUPLED: if (!tmo_err_q && !in_pkt_d && !inj_active) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (expire) state_d = (in_pkt_q && !reg_last_q) ? DRAIN : DECOUPLED;

    tmo_err_d = tmo_err_q;
    if (timeout_error_clear) tmo_err_d = 1'b0;
    if (expire)              tmo_err_d = 1'b1;

    dropped_d = dropped_q;
    if ((expire || (!pass_st && up_acc)) && (dropped_q != BEATS_DROPPED_MAX))
      dropped_d = dropped_q + 1'b1;
  end

  // State registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      reg_vld_q  <= 1'b0;
      reg_data_q <= '0;
      reg_id_q   <= '0;
      reg_dest_q <= '0;
      reg_keep_q <= '0;
      reg_last_q <= 1'b0;
      in_pkt_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      reg_vld_q  <= reg_vld_d;
      reg_data_q <= reg_data_d;
      reg_id_q   <= reg_id_d;
      reg_dest_q <= reg_dest_d;
      reg_keep_q <= reg_keep_d;
      reg_last_q <= reg_last_d;
      in_pkt_q   <= in_pkt_d;
      tmo_err_q  <= tmo_err_d;
      dropped_q  <= dropped_d;
    end
  end

`ifdef AXIS_SLAVE_VERIF_TLAST_INJECT_EN
  // Downstream packet tracking and terminator flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_pkt_q <= 1'b0;
      inj_q     <= 1'b0;
    end else begin
      out_pkt_q <= out_pkt_d;
      inj_q     <= inj_d;
    end
  end
`endif

  assign axis_m_tvalid     = reg_vld_q;
  assign axis_m_tdata      = reg_data_q;
  assign axis_m_tid        = reg_id_q;
  assign axis_m_tdest      = reg_dest_q;
  assign axis_m_tkeep      = reg_keep_q;
  assign axis_m_tlast      = reg_last_q;
  assign timeout_error_irq = tmo_err_q;
  assign beats_dropped     = dropped_q;

endmodule

// File: tb/tb_axi_stream_slave_verifier.sv
// Directed bench for axi_stream_slave_verifier with TIMEOUT_CYCLES = 8.
module tb_axi_stream_slave_verifier;

  localparam int W  = 64;
  localparam int IW = 4;
  localparam int DW = 4;
  localparam int TO = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [W-1:0]  s_tdata = '0;
  logic [IW-1:0] s_tid = '0;
  logic [DW-1:0] s_tdest = '0;
  logic [W/8-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [W-1:0]  m_tdata;
  logic [IW-1:0] m_tid;
  logic [DW-1:0] m_tdest;
  logic [W/8-1:0] m_tkeep;
  logic          m_tlast, m_tvalid, m_tready = 1'b0;
  logic          irq, err_clr = 1'b0;
  logic [15:0]   dropped;

  int n_chk = 0;
  int n_err = 0;
  int m_hs_cnt = 0;
  logic [63:0] m_q[$];

  axi_stream_slave_verifier #(
    .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IW), .AXIS_DEST_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_s_tdata(s_tdata), .axis_s_tid(s_tid), .axis_s_tdest(s_tdest),
    .axis_s_tkeep(s_tkeep), .axis_s_tlast(s_tlast), .axis_s_tvalid(s_tvalid),
    .axis_s_tready(s_tready),
    .axis_m_tdata(m_tdata), .axis_m_tid(m_tid), .axis_m_tdest(m_tdest),
    .axis_m_tkeep(m_tkeep), .axis_m_tlast(m_tlast), .axis_m_tvalid(m_tvalid),
    .axis_m_tready(m_tready),
    .timeout_error_irq(irq), .timeout_error_clear(err_clr), .beats_dropped(dropped)
  );

  always #5 aclk = ~aclk;

  // Record beats the slave takes (inputs are stable between edges)
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      m_hs_cnt++;
      m_q.push_back(m_tdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    s_tkeep  = '1;
    s_tid    = 4'h3;
    s_tdest  = 4'h5;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_irq", irq, 0);
    chk("rst_dropped", dropped, 0);
    step();
    aresetn = 1'b1;
    step();
    chk("idle_s_tready", s_tready, 1);

    // 4-beat packet, slave always ready
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'hA0 + 64'(i), i == 3);
      chk("pass_s_tready", s_tready, 1);
      step();
      chk("pass_m_tvalid", m_tvalid, 1);
      chk("pass_m_tdata", m_tdata, 64'hA0 + 64'(i));
      chk("pass_m_tlast", m_tlast, (i == 3) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 0, 1'b0);
    step();
    chk("pass_end_tvalid", m_tvalid, 0);
    chk("pass_irq", irq, 0);
    chk("pass_dropped", dropped, 0);
    chk("pass_hs", m_hs_cnt, 4);

    // Slave takes beat 1 of 6, then stalls on beat 2
    drive(1'b1, 64'hB1, 1'b0); step();
    drive(1'b1, 64'hB2, 1'b0); step();
    m_tready = 1'b0;
    drive(1'b1, 64'hB3, 1'b0);
    repeat (TO - 1) step();
    chk("pre_tmo_irq", irq, 0);
    chk("pre_tmo_tvalid", m_tvalid, 1);
    chk("pre_tmo_tdata", m_tdata, 64'hB2);
    chk("pre_tmo_s_tready", s_tready, 0);
    step();
    chk("tmo_irq", irq, 1);
    chk("tmo_tvalid", m_tvalid, 0);
    chk("tmo_dropped", dropped, 1);
    chk("drain_s_tready", s_tready, 1);
    step();
    drive(1'b1, 64'hB4, 1'b0); step();
    drive(1'b1, 64'hB5, 1'b0); step();
    drive(1'b1, 64'hB6, 1'b1); step();
    drive(1'b0, 0, 1'b0);
    chk("drain_dropped", dropped, 5);
    chk("drain_tvalid", m_tvalid, 0);
    chk("drain_hs", m_hs_cnt, 5);

    // Decoupled: two packets discarded, then clear lets the next through
    m_tready = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, 64'hC0 + 64'(p * 4 + i), i == 2);
        step();
      end
    drive(1'b0, 0, 1'b0);
    chk("dec_dropped", dropped, 11);
    chk("dec_hs", m_hs_cnt, 5);
    chk("dec_irq", irq, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_irq", irq, 0);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hD0 + 64'(i), i == 2);
      step();
      chk("rec_tvalid", m_tvalid, 1);
      chk("rec_tdata", m_tdata, 64'hD0 + 64'(i));
    end
    drive(1'b0, 0, 1'b0);
    step();
    chk("rec_hs", m_hs_cnt, 8);
    chk("rec_dropped", dropped, 11);

    // Stall of TIMEOUT-1 cycles twice: no timeout, timer restarts
    m_tready = 1'b0;
    drive(1'b1, 64'hE0, 1'b0); step();
    drive(1'b1, 64'hE1, 1'b1);
    repeat (TO - 1) step();
    chk("near_irq", irq, 0);
    chk("near_tdata", m_tdata, 64'hE0);
    m_tready = 1'b1; step();
    drive(1'b0, 0, 1'b0);
    m_tready = 1'b0;
    chk("near_tdata2", m_tdata, 64'hE1);
    repeat (TO - 1) step();
    chk("near_irq2", irq, 0);
    m_tready = 1'b1; step();
    chk("near_end_tvalid", m_tvalid, 0);
    chk("near_hs", m_hs_cnt, 10);
    chk("near_dropped", dropped, 11);
    chk("sb_a0", m_q[0], 64'hA0);
    chk("sb_a3", m_q[3], 64'hA3);
    chk("sb_b1", m_q[4], 64'hB1);
    chk("sb_d2", m_q[7], 64'hD2);
    chk("sb_e0", m_q[8], 64'hE0);
    chk("sb_e1", m_q[9], 64'hE1);

    // Clear in the same cycle as the timeout event: flag stays set
    m_tready = 1'b0;
    drive(1'b1, 64'hF0, 1'b1); step();
    drive(1'b0, 0, 1'b0);
    repeat (TO - 1) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("race_irq", irq, 1);
    chk("race_tvalid", m_tvalid, 0);
    chk("race_dropped", dropped, 12);
    m_tready = 1'b1;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("race_clr_irq", irq, 0);
    step(); step();

`ifdef AXIS_SLAVE_VERIF_TLAST_INJECT_EN
    // Timeout after two delivered beats: terminator closes the packet
    drive(1'b1, 64'h60, 1'b0); step();
    drive(1'b1, 64'h61, 1'b0); step();
    drive(1'b1, 64'h62, 1'b0); step();
    drive(1'b0, 0, 1'b0);
    m_tready = 1'b0;
    repeat (TO) step();
    chk("inj_irq", irq, 1);
    chk("inj_tvalid", m_tvalid, 1);
    chk("inj_tlast", m_tlast, 1);
    chk("inj_tkeep", m_tkeep, 0);
    chk("inj_tdata", m_tdata, 0);
    chk("inj_dropped", dropped, 13);
    repeat (5) step();
    chk("inj_hold", m_tvalid, 1);
    m_tready = 1'b1; step();
    chk("inj_done", m_tvalid, 0);
    chk("inj_last_beat", m_q[m_q.size() - 1], 0);
    drive(1'b1, 64'h63, 1'b1); step();
    drive(1'b0, 0, 1'b0);
    chk("inj_drop2", dropped, 14);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    step(); step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
